candidate_sorter: RTL
=====================

Name: candidate_sorter

Overview:
- Return side of the coarse-to-fine angle search: consumes the (theta, phi, score) stream produced while the sweep state machine walks each stage.
- Keeps the best keep_num candidates in score order and presents them as the packed candidate buffer the sweep engine reads to centre the next stage.
- Pulses sorted_rdy once the last angle of a stage has been inserted.

Parameters:
- DEPTH, 10, maximum number of retained candidates.
- ANG_W, 12, width of theta and phi.
- SCORE_W, 16, unsigned score width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  start of a new stage: empties the table and samples keep_num (driven from the sweep stage_trigger).
- keep_num  in  4  candidates to retain this stage; sampled only on clear.
- score_valid  in  1  qualifies score, score_theta, score_phi and last_in.
- score_theta  in  ANG_W  theta of the scored angle.
- score_phi  in  ANG_W  phi of the scored angle.
- score  in  SCORE_W  match score; higher is better.
- last_in  in  1  marks the final scored angle of the stage (sweep if_last_angle).
- candidate_angle_buffer  out  DEPTH*2*ANG_W  entry i at [(i+1)*24-1 -: 24] = {theta, phi}; entry 0 is best.
- best_score  out  SCORE_W  score of entry 0; 0 when the table is empty.
- count  out  4  number of valid entries, 0..keep_lim.
- sorted_rdy  out  1  one-cycle pulse: stage results are final.
- busy  out  1  high from the first accepted sample until the sorted_rdy pulse.

Behaviour:
- Reset (async, rst=1):
  - all entries invalid and zeroed; candidate_angle_buffer = 0; best_score = 0; count = 0.
  - sorted_rdy = 0; busy = 0; keep_lim = 1; FSM = IDLE.
- keep_lim, latched on clear:
  - keep_num = 0 gives 1.
  - keep_num > DEPTH gives DEPTH.
  - otherwise keep_lim = keep_num.
- Pipeline:
  - Stage A registers {score_valid, theta, phi, score, last_in}.
  - Stage B inserts the registered sample into the table on the next edge.
  - A sample accepted at edge N is visible on the outputs after edge N+1.
  - Throughput is one sample per clock with no backpressure.
- Insertion (parallel compare, one cycle):
  - gt[i] = !valid[i] || (score > score[i]), for i < keep_lim. Comparison is strict, so on a tie the earlier sample stays ahead.
  - p = lowest i with gt[i]=1. Entries p..keep_lim-2 shift down one place, entry p takes the new sample, and entry keep_lim-1 is dropped.
  - If no gt[i] is set, the table is unchanged.
  - Entries at index >= keep_lim stay invalid and output 0.
  - count increments until it reaches keep_lim, then holds.
- FSM:
  - IDLE -> COLLECT on the first score_valid.
  - COLLECT -> FLUSH when the Stage A register holds last_in=1.
  - FLUSH: the last sample is inserted on this edge, sorted_rdy is registered high for the next cycle, then -> DONE.
  - DONE: table frozen, score_valid ignored; -> IDLE on clear.
  - busy = (state == COLLECT || state == FLUSH).
- sorted_rdy:
  - asserted exactly one cycle, 2 cycles after the edge that accepted the last_in sample.
  - the outputs already hold the final table during the cycle sorted_rdy is high.
- clear behaviour:
  - clear has priority over any state, including mid-COLLECT and FLUSH. It invalidates all entries, cancels any pending sorted_rdy, sets count = 0 and sets FSM = IDLE.
  - The Stage B insertion of an older sample in the same cycle is discarded.
  - A score_valid sample in the same cycle as clear is captured into Stage A and inserted into the emptied table (FSM goes to COLLECT).
- last_in together with a score that beats no entry: the table is unchanged, but sorted_rdy still pulses.
- score_valid=0 with last_in=1: last_in is ignored.
- rst asserted mid-operation returns everything to the reset values immediately; no partial pulse.

Test Plan:
- Reset, then clear with keep_num=3; feed scores 5, 9, 7, 9(theta=40), 1 with theta=10,20,30,40,50 and phi=theta*2, last_in on the final sample -> entries {20,40},{40,80},{30,60}; rest 0; best_score=9; count=3; sorted_rdy high exactly 2 cycles after the last accepting edge.
- keep_num=0 -> behaves as 1; keep_num=15 -> 10 entries kept; feed 12 ascending scores -> entry 0 holds the 12th sample, entry 9 holds the 3rd.
- Sample with score 0 into an empty table -> accepted (an empty slot always loses); count=1.
- clear asserted mid-COLLECT while a sample is in Stage B, with score_valid=1 and score=4 in the same cycle -> old table and pending sample are dropped; the table holds only the score-4 sample and count=1.
- last_in on a sample worse than every entry of a full table -> table unchanged; sorted_rdy pulses once; in DONE a further score_valid changes nothing.
- rst pulse 1 cycle before the sorted_rdy pulse -> sorted_rdy never rises; all outputs zero; busy=0.

Source files
------------

// File: rtl/candidate_sorter_if.sv
// candidate_sorter_if: score stream in, sorted candidate table out
interface candidate_sorter_if #(
   parameter int DEPTH = 10,
   parameter int ANG_W = 12,
   parameter int SCORE_W = 16
);
   logic clear;
   logic [3:0] keep_num;
   logic score_valid;
   logic [ANG_W-1:0] score_theta;
   logic [ANG_W-1:0] score_phi;
   logic [SCORE_W-1:0] score;
   logic last_in;
   logic [DEPTH*2*ANG_W-1:0] candidate_angle_buffer;
   logic [SCORE_W-1:0] best_score;
   logic [3:0] count;
   logic sorted_rdy;
   logic busy;
   modport master (
      output clear, keep_num, score_valid, score_theta, score_phi, score, last_in,
      input candidate_angle_buffer, best_score, count, sorted_rdy, busy
   );
   modport slave (
      input clear, keep_num, score_valid, score_theta, score_phi, score, last_in,
      output candidate_angle_buffer, best_score, count, sorted_rdy, busy
   );
endinterface

// File: rtl/candidate_sorter.sv
// candidate_sorter: keeps the best keep_num (theta, phi, score) samples of a stage in score order
module candidate_sorter #(
   parameter int DEPTH = 10,
   parameter int ANG_W = 12,
   parameter int SCORE_W = 16
) (
   input logic clk,
   input logic rst,
   candidate_sorter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, DONE} state_t;
   state_t state_q;
   logic sorted_rdy_q, busy_q;
   logic a_valid_q, a_last_q;
   logic [ANG_W-1:0] a_theta_q, a_phi_q;
   logic [SCORE_W-1:0] a_score_q;
   logic [3:0] keep_lim_q, keep_lim_d, count_q, count_d;
   logic [DEPTH-1:0] vld_q, vld_d, gt;
   logic [ANG_W-1:0] th_q [DEPTH];
   logic [ANG_W-1:0] th_d [DEPTH];
   logic [ANG_W-1:0] ph_q [DEPTH];
   logic [ANG_W-1:0] ph_d [DEPTH];
   logic [SCORE_W-1:0] sc_q [DEPTH];
   logic [SCORE_W-1:0] sc_d [DEPTH];
   logic [DEPTH*2*ANG_W-1:0] cand_buf;
   logic a_final, accept;
   assign a_final = a_valid_q && a_last_q;
   // samples arriving after the stage's last angle, or once results are final, are ignored
   assign accept = bus.clear || state_q == IDLE || (state_q == COLLECT && !a_final);
   assign keep_lim_d = bus.keep_num == 4'd0 ? 4'd1 :
                       bus.keep_num > 4'(DEPTH) ? 4'(DEPTH) : bus.keep_num;
   // Stage A: register the incoming sample
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         a_valid_q <= 1'b0;
         a_last_q <= 1'b0;
         a_theta_q <= '0;
         a_phi_q <= '0;
         a_score_q <= '0;
      end else begin
         a_valid_q <= bus.score_valid && accept;
         a_last_q <= bus.score_valid && accept && bus.last_in;
         a_theta_q <= bus.score_theta;
         a_phi_q <= bus.score_phi;
         a_score_q <= bus.score;
      end
   // Stage B next table: the table is sorted, so gt is a suffix and its first bit is the insert slot
   always_comb begin
      logic gp, pv;
      logic [ANG_W-1:0] pt, pp;
      logic [SCORE_W-1:0] ps;
      gp = 1'b0;
      pv = 1'b0;
      pt = '0;
      pp = '0;
      ps = '0;
      gt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         gt[i] = a_valid_q && 4'(i) < keep_lim_q && (!vld_q[i] || a_score_q > sc_q[i]);
         vld_d[i] = gt[i] ? (gp ? pv : 1'b1) : vld_q[i];
         th_d[i] = gt[i] ? (gp ? pt : a_theta_q) : th_q[i];
         ph_d[i] = gt[i] ? (gp ? pp : a_phi_q) : ph_q[i];
         sc_d[i] = gt[i] ? (gp ? ps : a_score_q) : sc_q[i];
         pv = vld_q[i];
         pt = th_q[i];
         pp = ph_q[i];
         ps = sc_q[i];
         gp = gt[i];
      end
      count_d = |gt && count_q < keep_lim_q ? count_q + 4'd1 : count_q;
   end
   // Stage B: commit the insertion; clear empties the table and drops the in-flight insert
   always_ff @(posedge clk or posedge rst)
      if (rst || bus.clear) begin
         vld_q <= '0;
         count_q <= '0;
         keep_lim_q <= rst ? 4'd1 : keep_lim_d;
         for (int i = 0; i < DEPTH; i++) begin
            th_q[i] <= '0;
            ph_q[i] <= '0;
            sc_q[i] <= '0;
         end
      end else begin
         vld_q <= vld_d;
         count_q <= count_d;
         th_q <= th_d;
         ph_q <= ph_d;
         sc_q <= sc_d;
      end
   // stage control with registered busy and sorted_rdy
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         busy_q <= 1'b0;
         sorted_rdy_q <= 1'b0;
      end else if (bus.clear) begin
         state_q <= bus.score_valid ? COLLECT : IDLE;
         busy_q <= bus.score_valid;
         sorted_rdy_q <= 1'b0;
      end else begin
         sorted_rdy_q <= 1'b0;
         case (state_q)
            IDLE: if (bus.score_valid) begin
               state_q <= COLLECT;
               busy_q <= 1'b1;
            end
            COLLECT: if (a_final) state_q <= FLUSH;
            FLUSH: begin
               state_q <= DONE;
               busy_q <= 1'b0;
               sorted_rdy_q <= 1'b1;
            end
            default: state_q <= DONE;
         endcase
      end
   // pack entries, best first
   always_comb begin
      cand_buf = '0;
      for (int i = 0; i < DEPTH; i++) cand_buf[i*2*ANG_W +: 2*ANG_W] = {th_q[i], ph_q[i]};
   end
   assign bus.candidate_angle_buffer = cand_buf;
   assign bus.best_score = sc_q[0];
   assign bus.count = count_q;
   assign bus.sorted_rdy = sorted_rdy_q;
   assign bus.busy = busy_q;
endmodule
